// File: rtl/lm_sm_sequencer.sv
// Expands LM/SM multi-register instructions into one micro-op per selected register;
// all other instructions pass straight through with one cycle of latency.
module lm_sm_sequencer #(
    parameter logic [15:0] NOP_IR = 16'hE000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_ir,
    input  logic [15:0] in_pc,
    input  logic        stall,
    input  logic        flush,
    output logic        in_ready,
    output logic        hold_fetch,
    output logic        out_valid,
    output logic [15:0] out_ir,
    output logic [15:0] out_pc,
    output logic        first_multiple
);

    typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;

    state_t      state_r, state_s;
    logic [7:0]  remaining_r, remaining_s;
    logic [3:0]  op_r, op_s;
    logic [2:0]  ra_r, ra_s;
    logic [15:0] pc_r, pc_s;
    logic        out_valid_r, out_valid_s;
    logic [15:0] out_ir_r, out_ir_s;
    logic [15:0] out_pc_r, out_pc_s;
    logic        first_r, first_s;

    logic        is_lmsm_s;
    logic [7:0]  mask_s;
    logic [2:0]  k_in_s, k_seq_s;
    logic [7:0]  rem_in_s, rem_seq_s;

    // Index of the least-significant set bit; 0 when no bit is set.
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        lowest_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) lowest_bit = 3'(i);
        end
    endfunction

    function automatic logic [7:0] clear_bit(input logic [7:0] m, input logic [2:0] k);
        clear_bit = m & ~(8'h01 << k);
    endfunction

    assign is_lmsm_s  = (in_ir[15:13] == 3'b011);
    assign mask_s     = in_ir[7:0];
    assign k_in_s     = lowest_bit(mask_s);
    assign rem_in_s   = clear_bit(mask_s, k_in_s);
    assign k_seq_s    = lowest_bit(remaining_r);
    assign rem_seq_s  = clear_bit(remaining_r, k_seq_s);

    assign in_ready       = !stall && !flush && (state_r == IDLE);
    assign hold_fetch     = (state_r == SEQ);
    assign out_valid      = out_valid_r;
    assign out_ir         = out_ir_r;
    assign out_pc         = out_pc_r;
    assign first_multiple = first_r;

    // Next-state and micro-op generation; flush beats stall beats new input.
    always_comb begin
        state_s     = state_r;
        remaining_s = remaining_r;
        op_s        = op_r;
        ra_s        = ra_r;
        pc_s        = pc_r;
        out_valid_s = out_valid_r;
        out_ir_s    = out_ir_r;
        out_pc_s    = out_pc_r;
        first_s     = first_r;
        if (flush) begin
            state_s     = IDLE;
            remaining_s = 8'h00;
            out_valid_s = 1'b0;
            first_s     = 1'b0;
        end else if (stall) begin
            state_s = state_r;
        end else if (state_r == SEQ) begin
            remaining_s = rem_seq_s;
            state_s     = (rem_seq_s != 8'h00) ? SEQ : IDLE;
            out_valid_s = 1'b1;
            out_ir_s    = {op_r, ra_r, k_seq_s, (rem_seq_s == 8'h00), 5'b00000};
            out_pc_s    = pc_r;
            first_s     = 1'b0;
        end else if (in_valid) begin
            out_valid_s = 1'b1;
            out_pc_s    = in_pc;
            if (is_lmsm_s && (mask_s != 8'h00)) begin
                op_s        = in_ir[15:12];
                ra_s        = in_ir[11:9];
                pc_s        = in_pc;
                remaining_s = rem_in_s;
                state_s     = (rem_in_s != 8'h00) ? SEQ : IDLE;
                out_ir_s    = {in_ir[15:12], in_ir[11:9], k_in_s, (rem_in_s == 8'h00), 5'b00000};
                first_s     = 1'b1;
            end else if (is_lmsm_s) begin
                out_ir_s = NOP_IR;
                first_s  = 1'b0;
            end else begin
                out_ir_s = in_ir;
                first_s  = 1'b0;
            end
        end else begin
            out_valid_s = 1'b0;
            first_s     = 1'b0;
        end
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            remaining_r <= 8'h00;
            op_r        <= 4'h0;
            ra_r        <= 3'd0;
            pc_r        <= 16'h0000;
            out_valid_r <= 1'b0;
            out_ir_r    <= 16'h0000;
            out_pc_r    <= 16'h0000;
            first_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            remaining_r <= remaining_s;
            op_r        <= op_s;
            ra_r        <= ra_s;
            pc_r        <= pc_s;
            out_valid_r <= out_valid_s;
            out_ir_r    <= out_ir_s;
            out_pc_r    <= out_pc_s;
            first_r     <= first_s;
        end
    end

endmodule

// File: doc/lm_sm_sequencer.md
LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 SHALL have parameter NOP_IR, default 16'hE000, the instruction word emitted for a zero-mask LM/SM.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, IF/ID word present.
REQ-005 SHALL have port in_ir, input, 16, instruction from IF/ID.
REQ-006 SHALL have port in_pc, input, 16, PC of in_ir.
REQ-007 SHALL have port stall, input, 1, downstream hold request.
REQ-008 SHALL have port flush, input, 1, squash request from the hazard unit.
REQ-009 SHALL have port in_ready, output, 1, input accepted this cycle.
REQ-010 SHALL have port hold_fetch, output, 1, tells fetch to freeze PC and disable IR write.
REQ-011 SHALL have port out_valid, output, 1, micro-op valid to decode.
REQ-012 SHALL have port out_ir, output, 16, micro-op word.
REQ-013 SHALL have port out_pc, output, 16, PC carried with the micro-op.
REQ-014 SHALL have port first_multiple, output, 1, marks the first micro-op of an LM/SM; selects base address from register rather than incremented address.

Function
REQ-015 SHALL decode LM as in_ir[15:12]=4'b0110 and SM as 4'b0111; rA=in_ir[11:9]; mask=in_ir[7:0], bit i selects register Ri.
REQ-016 SHALL hold state as a registered remaining-mask (8 bits), latched opcode/rA/PC, and output registers; FSM states IDLE (remaining==0) and SEQ (remaining!=0).
REQ-017 SHALL drive in_ready = !stall && !flush && state==IDLE, combinationally.
REQ-018 SHALL drive hold_fetch = (state==SEQ), taken from a register.
REQ-019 SHALL, on acceptance of a non-LM/SM instruction, present out_ir=in_ir, out_pc=in_pc, out_valid=1, first_multiple=0 on the next cycle (latency 1).
REQ-020 SHALL, on acceptance of LM/SM with mask!=0, emit the micro-op for the lowest set bit k on the next cycle with first_multiple=1, and load remaining=mask with bit k cleared.
REQ-021 SHALL format each micro-op as {op[3:0], rA[2:0], k[2:0], last, 5'b0}, where last=1 if and only if this is the final micro-op of the sequence.
REQ-022 SHALL, in SEQ with stall=0, emit the lowest set bit of remaining each cycle with first_multiple=0, and clear that bit; return to IDLE when remaining reaches 0.
REQ-023 SHALL carry the LM/SM in_pc on every micro-op of the sequence.
REQ-024 SHALL emit exactly popcount(mask) micro-ops, in ascending register order.
REQ-025 SHALL, on acceptance of LM/SM with mask==0, emit one word out_ir=NOP_IR, with first_multiple=0, and stay in IDLE.
REQ-026 SHALL, when stall=1, hold all output and state registers unchanged and accept no input.
REQ-027 SHALL, when in IDLE with in_valid=0 and stall=0, drive out_valid=0 on the next cycle.
REQ-028 SHALL, when flush=1, on the next edge set out_valid=0, remaining=0, state=IDLE, and first_multiple=0.
REQ-029 SHALL give flush priority over stall, and stall priority over in_valid.

Reset
REQ-030 SHALL, while reset=0, immediately force: out_valid=0, out_ir=16'h0000, out_pc=16'h0000, first_multiple=0, hold_fetch=0, remaining=0, state=IDLE.
REQ-031 SHALL abandon any in-progress sequence on reset, with no partial micro-op issued after release.
REQ-032 SHALL behave as IDLE from the first rising edge after reset deasserts.

Verification
REQ-033 SHALL pass passthrough: in_ir=16'h1050, in_pc=16'h0010 -> next cycle out_valid=1, out_ir=16'h1050, out_pc=16'h0010, first_multiple=0, hold_fetch=0.
REQ-034 SHALL pass LM expansion: in_ir=16'h6605, in_pc=16'h0020 -> cycle1 out_ir=16'h6600, first_multiple=1, hold_fetch=1, in_ready=0; cycle2 out_ir=16'h66A0, first_multiple=0, out_pc=16'h0020; cycle3 hold_fetch=0, in_ready=1.
REQ-035 SHALL pass zero mask: in_ir=16'h7200 -> one cycle out_ir=16'hE000, hold_fetch stays 0.
REQ-036 SHALL pass full mask with stall: in_ir=16'h76FF with stall=1 for 2 cycles after the third micro-op -> 8 micro-ops R0..R7, the third held for 3 cycles, and only the R7 micro-op has bit5=1.
REQ-037 SHALL pass flush mid-sequence: flush=1 after the second micro-op of 16'h66FF -> next cycle out_valid=0, hold_fetch=0, in_ready=1, and no further micro-ops.
REQ-038 SHALL pass asynchronous reset mid-sequence: reset=0 between clock edges -> all outputs 0 before the next edge; after release, the next accepted 16'h1050 passes through normally.
